multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 155 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/exec/mem/writeback and drives datapath strobes.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes halt the machine instead of retiring as a NOP.
module multicycle_ctrl #(
  parameter int unsigned PC_W  = 26,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [25:0]      target,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [PC_W-1:0]  pc,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic             busy,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam logic [5:0] OpAdd  = 6'd1;
  localparam logic [5:0] OpSub  = 6'd2;
  localparam logic [5:0] OpAddi = 6'd5;
  localparam logic [5:0] OpLw   = 6'd13;
  localparam logic [5:0] OpSw   = 6'd14;
  localparam logic [5:0] OpBeq  = 6'd15;
  localparam logic [5:0] OpBlt  = 6'd19;
  localparam logic [5:0] OpJ    = 6'd21;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             legal;
  logic             in_dp;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OpAdd, OpSub, OpAddi, OpLw, OpSw, OpBeq, OpBlt, OpJ: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    retire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = StDecode;
      end
      StDecode: begin
        if (opcode == OpJ) begin
          pc_d   = PC_W'(target);
          retire = 1'b1;
        end else if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = StHalt;
`else
          retire = 1'b1;
`endif
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (opcode)
          OpBeq, OpBlt: begin
            // Branch target is absolute and zero-extended from the low 16 bits.
            if (zero) pc_d = PC_W'(target[15:0]);
            retire = 1'b1;
          end
          OpLw, OpSw: state_d = StMem;
          default:    state_d = StWb;
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          if (opcode == OpLw) state_d = StWb;
          else                retire  = 1'b1;
        end
      end
      StWb: begin
        retire = 1'b1;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    if (retire) state_d = run ? StFetch : StIdle;
  end

  // Selects are only meaningful once the instruction is past decode.
  assign in_dp = (state_d == StExec) || (state_d == StMem) || (state_d == StWb);

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      cnt_q      <= '0;
      ir_write   <= 1'b0;
      reg_write  <= 1'b0;
      reg_dst    <= 1'b0;
      alu_src    <= 1'b0;
      mem_to_reg <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      ir_write   <= (state_d == StFetch);
      reg_write  <= (state_d == StWb);
      reg_dst    <= in_dp && ((opcode == OpAdd) || (opcode == OpSub));
      alu_src    <= in_dp && ((opcode == OpAddi) || (opcode == OpLw) || (opcode == OpSw));
      mem_to_reg <= in_dp && (opcode == OpLw);
      mem_read   <= (state_d == StMem) && (opcode == OpLw);
      mem_write  <= (state_d == StMem) && (opcode == OpSw);
      busy       <= (state_d != StIdle) && (state_d != StHalt);
      halted     <= (state_d == StHalt);
    end
  end

  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; honours ILLEGAL_TRAP_EN like the RTL.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [25:0] target = 26'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic [25:0] pc;
  logic        ir_write, reg_write, reg_dst, alu_src, mem_to_reg, mem_read, mem_write;
  logic        busy, halted;
  logic [2:0]  state;
  logic [3:0]  instr_count;

  int checks = 0;
  int failures = 0;

  multicycle_ctrl #(.PC_W(26), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .target(target), .zero(zero),
    .mem_ready(mem_ready), .pc(pc), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .busy(busy), .halted(halted), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; opcode = 6'd5;
    tick(); tick();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (pc !== 26'd0) begin failures++; $display("FAIL reset_pc: got %0d want 0", pc); end
    checks++; if (instr_count !== 4'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", instr_count); end
    checks++;
    if ({ir_write, reg_write, reg_dst, alu_src, mem_to_reg, mem_read, mem_write, busy, halted} !== 9'd0) begin
      failures++; $display("FAIL reset_strobes: got %b want 0", {ir_write, reg_write, reg_dst, alu_src,
                           mem_to_reg, mem_read, mem_write, busy, halted});
    end
    reset = 1'b0; run = 1'b0;
    tick();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL idle_hold: got %0d want 0", state); end
  endtask

  task automatic test_addi();
    int exp_st[5];
    exp_st = '{1, 2, 3, 5, 1};
    do_reset();
    opcode = 6'd5; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (state !== 3'(exp_st[i])) begin failures++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
      checks++; if (reg_write !== (exp_st[i] == 5)) begin failures++; $display("FAIL addi_regwrite[%0d]: got %b", i, reg_write); end
      checks++; if (ir_write !== (exp_st[i] == 1)) begin failures++; $display("FAIL addi_irwrite[%0d]: got %b", i, ir_write); end
      if (exp_st[i] == 3 || exp_st[i] == 5) begin
        checks++; if (alu_src !== 1'b1) begin failures++; $display("FAIL addi_alusrc[%0d]: got %b want 1", i, alu_src); end
      end
    end
    checks++; if (pc !== 26'd1) begin failures++; $display("FAIL addi_pc: got %0d want 1", pc); end
    checks++; if (instr_count !== 4'd1) begin failures++; $display("FAIL addi_cnt: got %0d want 1", instr_count); end
  endtask

  task automatic test_lw();
    int rd = 0;
    int both = 0;
    do_reset();
    opcode = 6'd13; run = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 7) mem_ready = 1'b1;
      if (mem_read) rd++;
      if (mem_read && mem_write) both++;
      if (i == 8) begin
        checks++; if (state !== 3'd5) begin failures++; $display("FAIL lw_wb_state: got %0d want 5", state); end
        checks++; if (mem_to_reg !== 1'b1) begin failures++; $display("FAIL lw_memtoreg: got %b want 1", mem_to_reg); end
        checks++; if (reg_write !== 1'b1) begin failures++; $display("FAIL lw_regwrite: got %b want 1", reg_write); end
      end
    end
    checks++; if (rd != 4) begin failures++; $display("FAIL lw_memread_cycles: got %0d want 4", rd); end
    checks++; if (both != 0) begin failures++; $display("FAIL lw_rd_wr_overlap: got %0d want 0", both); end
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL lw_total_8: got state %0d want 1", state); end
    checks++; if (instr_count !== 4'd1) begin failures++; $display("FAIL lw_cnt: got %0d want 1", instr_count); end
  endtask

  task automatic test_branch();
    int ops[4];
    int zs[4];
    int exp_pc[4];
    ops = '{15, 15, 19, 19}; zs = '{1, 0, 1, 0}; exp_pc = '{12, 8, 12, 8};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      opcode = 6'd21; target = 26'd7; run = 1'b1;
      tick(); tick(); tick();
      checks++; if (pc !== 26'd7) begin failures++; $display("FAIL br%0d_setup_pc: got %0d want 7", k, pc); end
      opcode = 6'(ops[k]); target = 26'h2A0000C; zero = 1'(zs[k]);
      tick();
      checks++; if (pc !== 26'd8) begin failures++; $display("FAIL br%0d_decode_pc: got %0d want 8", k, pc); end
      tick();
      checks++; if (state !== 3'd3) begin failures++; $display("FAIL br%0d_exec: got %0d want 3", k, state); end
      tick();
      checks++; if (state !== 3'd1) begin failures++; $display("FAIL br%0d_retire: got %0d want 1", k, state); end
      checks++; if (pc !== 26'(exp_pc[k])) begin failures++; $display("FAIL br%0d_pc: got %0d want %0d", k, pc, exp_pc[k]); end
      checks++; if (instr_count !== 4'd2) begin failures++; $display("FAIL br%0d_cnt: got %0d want 2", k, instr_count); end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    logic bad = 1'b0;
    do_reset();
    opcode = 6'd21; target = 26'd2; run = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      bad |= reg_write | mem_read | mem_write;
      if (i == 2) begin
        checks++; if (pc !== 26'd1) begin failures++; $display("FAIL j_decode_pc: got %0d want 1", pc); end
      end
    end
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL j_retire: got %0d want 1", state); end
    checks++; if (pc !== 26'd2) begin failures++; $display("FAIL j_pc: got %0d want 2", pc); end
    target = 26'h3FFFFFF;
    tick(); tick();
    bad |= reg_write | mem_read | mem_write;
    checks++; if (pc !== 26'h3FFFFFF) begin failures++; $display("FAIL j_pc_max: got %0h want 3ffffff", pc); end
    tick();
    checks++; if (pc !== 26'd0) begin failures++; $display("FAIL pc_wrap: got %0h want 0", pc); end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL j_strobes: got %b want 0", bad); end
  endtask

  task automatic test_sw_reset();
    do_reset();
    opcode = 6'd21; target = 26'd5; run = 1'b1;
    tick(); tick(); tick();
    opcode = 6'd14; mem_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if ({state, mem_write, mem_read} !== {3'd4, 1'b1, 1'b0}) begin
      failures++; $display("FAIL sw_mem1: got st=%0d wr=%b rd=%b want st=4 wr=1 rd=0", state, mem_write, mem_read);
    end
    tick();
    checks++; if ({state, mem_write} !== {3'd4, 1'b1}) begin
      failures++; $display("FAIL sw_mem2: got st=%0d wr=%b want st=4 wr=1", state, mem_write);
    end
    reset = 1'b1;
    tick();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL swrst_state: got %0d want 0", state); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL swrst_memwrite: got %b want 0", mem_write); end
    checks++; if (pc !== 26'd0) begin failures++; $display("FAIL swrst_pc: got %0d want 0", pc); end
    checks++; if (instr_count !== 4'd0) begin failures++; $display("FAIL swrst_cnt: got %0d want 0", instr_count); end
    reset = 1'b0; mem_ready = 1'b1; run = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 6'd63; run = 1'b1;
    tick(); tick();
    checks++; if ({reg_write, mem_read, mem_write} !== 3'd0) begin
      failures++; $display("FAIL ill_decode_strobes: got %b want 000", {reg_write, mem_read, mem_write});
    end
    tick();
`ifdef ILLEGAL_TRAP_EN
    checks++; if ({state, halted, busy} !== {3'd6, 1'b1, 1'b0}) begin
      failures++; $display("FAIL ill_halt: got st=%0d h=%b b=%b want st=6 h=1 b=0", state, halted, busy);
    end
    tick(); tick(); tick();
    checks++; if ({state, halted} !== {3'd6, 1'b1}) begin failures++; $display("FAIL ill_hold: got st=%0d h=%b", state, halted); end
    checks++; if (instr_count !== 4'd0) begin failures++; $display("FAIL ill_cnt: got %0d want 0", instr_count); end
    do_reset();
    checks++; if ({state, halted} !== {3'd0, 1'b0}) begin failures++; $display("FAIL ill_reset: got st=%0d h=%b", state, halted); end
`else
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL ill_nop_state: got %0d want 1", state); end
    checks++; if (instr_count !== 4'd1) begin failures++; $display("FAIL ill_nop_cnt: got %0d want 1", instr_count); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL ill_nop_halted: got %b want 0", halted); end
    checks++; if (pc !== 26'd1) begin failures++; $display("FAIL ill_nop_pc: got %0d want 1", pc); end
`endif
  endtask

  task automatic test_back_to_back();
    int ops[7];
    int lat[7];
    int dst[7];
    int src[7];
    int n;
    ops = '{1, 2, 14, 13, 15, 5, 21};
    lat = '{4, 4, 4, 5, 3, 4, 2};
    dst = '{1, 1, 0, 0, 0, 0, 0};
    src = '{0, 0, 1, 1, 0, 1, 0};
    do_reset();
    run = 1'b1; target = 26'd40;
    tick();
    for (int k = 0; k < 7; k++) begin
      opcode = 6'(ops[k]);
      n = 0;
      do begin
        tick();
        n++;
        if (state == 3'd3) begin
          checks++; if ({reg_dst, alu_src} !== {1'(dst[k]), 1'(src[k])}) begin
            failures++; $display("FAIL b2b%0d_selects: got %b%b want %0d%0d", k, reg_dst, alu_src, dst[k], src[k]);
          end
        end
      end while (state != 3'd1 && n < 20);
      checks++; if (n != lat[k]) begin failures++; $display("FAIL b2b%0d_latency: got %0d want %0d", k, n, lat[k]); end
    end
    checks++; if (pc !== 26'd40) begin failures++; $display("FAIL b2b_pc: got %0d want 40", pc); end
    checks++; if (instr_count !== 4'd7) begin failures++; $display("FAIL b2b_cnt: got %0d want 7", instr_count); end
  endtask

  task automatic test_run_drop();
    do_reset();
    opcode = 6'd1; run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick(); tick();
    checks++; if ({state, busy} !== {3'd5, 1'b1}) begin failures++; $display("FAIL drop_wb: got st=%0d b=%b want 5 1", state, busy); end
    tick();
    checks++; if ({state, busy} !== {3'd0, 1'b0}) begin failures++; $display("FAIL drop_idle: got st=%0d b=%b want 0 0", state, busy); end
    checks++; if (instr_count !== 4'd1) begin failures++; $display("FAIL drop_cnt: got %0d want 1", instr_count); end
    tick();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL drop_stay: got %0d want 0", state); end
  endtask

  task automatic test_count_wrap();
    do_reset();
    opcode = 6'd21; target = 26'd0; run = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick(); tick();
    end
    checks++; if (instr_count !== 4'd15) begin failures++; $display("FAIL cnt_max: got %0d want 15", instr_count); end
    tick(); tick();
    checks++; if (instr_count !== 4'd0) begin failures++; $display("FAIL cnt_wrap: got %0d want 0", instr_count); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw();
    test_branch();
    test_jump();
    test_sw_reset();
    test_illegal();
    test_back_to_back();
    test_run_drop();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
